uart_transmitter: RTL and testbench
===================================

# uart_transmitter

Serial transmit half of the board's 8N1 UART link. The CPU side pushes bytes through a valid/ready handshake into a small FIFO, and the block shifts each byte out on `serial_out`, which drives `FPGA_SERIAL_TX`. It runs entirely in the CPU clock domain, nominally `cpu_clk_g` at 50 MHz. It is the counterpart of the receiver that consumes `FPGA_SERIAL_RX`.

## Interface
- `CLOCK_FREQ`, default 50_000_000: clock frequency in Hz.
- `BAUD_RATE`, default 115_200: line rate in bits/s.
- `FIFO_DEPTH`, default 4: number of byte entries; power of two, ≥2.
- Derived constant: `SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE`, integer-truncated (434 at the defaults), written N below.

Ports:
- `clk`, input, 1: single clock for all state.
- `rst`, input, 1: synchronous, active-low reset. Sampled on the `clk` rising edge; `rst==0` resets.
- `data_in`, input, 8: byte to transmit.
- `data_in_valid`, input, 1: producer has a byte on `data_in`.
- `data_in_ready`, output, 1: FIFO can accept a byte.
- `serial_out`, output, 1: UART line; idles high.
- `busy`, output, 1: a frame is on the line or the FIFO is non-empty.
- `fifo_count`, output, clog2(FIFO_DEPTH)+1: number of bytes queued, excluding the byte being shifted.

## Operation
- **Push:** on a rising edge with `data_in_valid & data_in_ready`, `data_in` is written at the write pointer and the count increments.
- **Ready:** `data_in_ready = rst & (fifo_count < FIFO_DEPTH)`, combinational from registered state.
- **Pointers:** read and write pointers wrap modulo `FIFO_DEPTH`.
- **FSM states:** IDLE, START, DATA, STOP. A baud counter runs 0..N-1; a bit index runs 0..7.
- **IDLE:** `serial_out=1`. If `fifo_count>0`, pop the head into the shift register and go to START.
- **START:** `serial_out=0` for N cycles, then go to DATA with bit index 0.
- **DATA:** `serial_out = shift[0]`, LSB first. Every N cycles, shift right and increment the index. After bit 7's N cycles, go to STOP.
- **STOP:** `serial_out=1` for N cycles. On the last STOP cycle:
  - if `fifo_count>0`, pop and go directly to START, so back-to-back frames have no idle gap;
  - otherwise go to IDLE.
- **Simultaneous push and pop:** legal whenever not full. The count is unchanged and both pointers advance.
- **Push into an empty FIFO while in IDLE:** the byte is not visible to the FSM until the following cycle.
- **Full FIFO:** `data_in_ready=0`, even if a pop occurs in the same cycle. No overwrite is possible.
- **busy:** `(state != IDLE) | (fifo_count != 0)`.

## Timing
- **Reset values** (after a rising edge with `rst==0`): state IDLE, `serial_out=1`, `busy=0`, `fifo_count=0`, pointers 0, baud counter 0. `data_in_ready=0` while `rst==0`, and 1 on the first cycle after release.
- **Reset mid-frame:** the frame is aborted, `serial_out=1` on the next cycle, and queued bytes are discarded. No partial stop bit is emitted.
- **Latency from idle:** byte accepted at edge E0 → pop at edge E1 → `serial_out` low from E1.
- **Frame length:** exactly 10·N cycles.
- **Bit timing:** bit k (0 = start, 9 = stop) occupies cycles E1+k·N through E1+(k+1)·N−1.
- **Output registering:** `serial_out` is registered, with no combinational path from `data_in`.
- **Back-to-back frames:** the next start bit begins on the cycle after the previous stop bit's last cycle.
- **Data sampling:** the byte value is captured at push time. Later changes to `data_in` have no effect.

## Test plan
All scenarios use `CLOCK_FREQ=800`, `BAUD_RATE=100`, giving N=8.
- **Reset state:** hold `rst=0` for 3 cycles, then release → `serial_out=1`, `busy=0`, `fifo_count=0`, `data_in_ready=0` during reset and 1 one cycle after release.
- **Single byte:** push 0x55 while idle → line reads 0,1,0,1,0,1,0,1,0,1, each bit 8 cycles wide, starting one cycle after acceptance. `busy` falls after 80 cycles and the line stays high.
- **Fill to full:** push 0xA3, 0x0F, 0xFF, 0x00, 0x81 on consecutive cycles.
  - First byte pops immediately; the next 4 fill the FIFO, after which `data_in_ready=0` and `fifo_count=4`.
  - Five frames follow with no idle cycles between stop and start; decode order is 0xA3, 0x0F, 0xFF, 0x00, 0x81.
- **Push while full with a pop in the same cycle:** hold `data_in_valid` high when `fifo_count=4` on the cycle a pop occurs → the byte is not accepted that cycle and is accepted on the next cycle. No byte is lost or duplicated.
- **Reset mid-frame:** assert `rst=0` during data bit 3 of 0xF0 with 2 bytes queued → `serial_out=1` on the next cycle and `fifo_count=0`. After release, no frame is emitted for 100 cycles.
- **Concurrent push and pop:** with one byte queued, push on the exact cycle of the STOP→START pop → `fifo_count` stays at 1 and the pointers wrap correctly across 8+ frames, checked against a scoreboard.

Source files
------------

// File: rtl/uart_transmitter.sv
// uart_transmitter: 8N1 serial transmitter fed by a small byte FIFO.
//
// Producer side: strict valid/ready. A byte transfers on a rising edge where
// data_in_valid and data_in_ready are both high; data_in_valid may be held
// while data_in_ready is low and the byte transfers on the first edge where
// ready is seen high. data_in_ready depends only on registered state and rst,
// never on data_in_valid.
//
// Line side: each frame is a low start bit, eight data bits LSB first, and a
// high stop bit, each held for SYMBOL_EDGE_TIME clock cycles. serial_out is
// driven straight from a flop so it never glitches.
module uart_transmitter #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    data_in,
    input  logic                          data_in_valid,
    output logic                          data_in_ready,
    output logic                          serial_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    // Cycles per bit on the line, truncated toward zero.
    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;

    // Baud counter width; a one-cycle symbol still needs a 1-bit counter.
    localparam int BW = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;
    // FIFO pointer width and occupancy width (occupancy must reach FIFO_DEPTH).
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [BW-1:0] BAUD_LAST = BW'(SYMBOL_EDGE_TIME - 1);
    localparam logic [CW-1:0] DEPTH     = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          state;
    logic [BW-1:0]   baud_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    logic            push;
    logic            pop;
    logic            baud_last;

    // Ready is withheld during reset and whenever the FIFO is full, even if
    // the FSM is popping this cycle, so a full FIFO can never be overwritten.
    assign data_in_ready = rst & (count < DEPTH);
    assign push          = data_in_valid & data_in_ready;
    assign baud_last     = (baud_cnt == BAUD_LAST);

    assign fifo_count    = count;
    assign busy          = (state != IDLE) | (count != '0);

    // Pop when the FSM is ready to load a new byte: immediately from IDLE, or
    // on the final stop-bit cycle so back-to-back frames have no idle gap.
    always_comb begin
        pop = 1'b0;
        if (count != '0) begin
            case (state)
                IDLE:    pop = 1'b1;
                STOP:    pop = baud_last;
                default: pop = 1'b0;
            endcase
        end
    end

    // FIFO storage: written on every accepted byte; contents need no reset
    // because the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Frame sequencer: owns the line, the baud counter and the shift register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            serial_out <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    baud_cnt   <= '0;
                    bit_idx    <= '0;
                    serial_out <= 1'b1;
                    if (pop) begin
                        shift      <= mem[rd_ptr];
                        serial_out <= 1'b0;
                        state      <= START;
                    end
                end

                START: begin
                    if (baud_last) begin
                        baud_cnt   <= '0;
                        bit_idx    <= '0;
                        serial_out <= shift[0];
                        state      <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end

                DATA: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            serial_out <= 1'b1;
                            state      <= STOP;
                        end else begin
                            // Present the next bit in the same edge as the shift.
                            shift      <= {1'b0, shift[7:1]};
                            serial_out <= shift[1];
                            bit_idx    <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end

                STOP: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        if (pop) begin
                            shift      <= mem[rd_ptr];
                            serial_out <= 1'b0;
                            state      <= START;
                        end else begin
                            serial_out <= 1'b1;
                            state      <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end

                default: begin
                    baud_cnt   <= '0;
                    bit_idx    <= '0;
                    serial_out <= 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: directed checks of the 8N1 transmitter at N = 8
// cycles per bit and a 4-entry FIFO.
module tb_uart_transmitter;

    localparam int CLOCK_FREQ = 800;
    localparam int BAUD_RATE  = 100;
    localparam int FIFO_DEPTH = 4;

    typedef struct {
        logic [7:0] data;
        logic [9:0] line;   // transmission order, MSB is the start bit
    } frame_vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       data_in_valid = 1'b0;
    logic       data_in_ready;
    logic       serial_out;
    logic       busy;
    logic [2:0] fifo_count;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    uart_transmitter #(
        .CLOCK_FREQ (CLOCK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .serial_out    (serial_out),
        .busy          (busy),
        .fifo_count    (fifo_count)
    );

    // Clock: 10 time-unit period.
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Push one byte while idle and check every cycle of its frame.
    task automatic send_frame(input logic [7:0] d, input logic [9:0] line);
        data_in       = d;
        data_in_valid = 1'b1;
        check("accept_ready", {31'd0, data_in_ready}, 32'd1);
        tick();
        data_in_valid = 1'b0;
        data_in       = ~d;
        check("count_after_push", {29'd0, fifo_count}, 32'd1);
        check("line_high_at_push", {31'd0, serial_out}, 32'd1);
        tick();
        check("count_after_pop", {29'd0, fifo_count}, 32'd0);
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < 8; j++) begin
                check($sformatf("frame_%02h_bit%0d", d, k), {31'd0, serial_out}, {31'd0, line[9-k]});
                check("busy_in_frame", {31'd0, busy}, 32'd1);
                tick();
            end
        end
        check("busy_after_frame", {31'd0, busy}, 32'd0);
        check("line_after_frame", {31'd0, serial_out}, 32'd1);
    endtask

    // Find a start bit (bounded) and sample each bit mid-symbol.
    task automatic decode_frame(output logic [7:0] b);
        int waited;
        waited = 0;
        b = 8'h00;
        while (serial_out !== 1'b0 && waited < 300) begin
            tick();
            waited++;
        end
        if (serial_out !== 1'b0) begin
            check("frame_start_timeout", {31'd0, serial_out}, 32'd0);
            return;
        end
        repeat (4) tick();
        check("decode_start_bit", {31'd0, serial_out}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (8) tick();
            b[i] = serial_out;
        end
        repeat (8) tick();
        check("decode_stop_bit", {31'd0, serial_out}, 32'd1);
        repeat (4) tick();
    endtask

    initial begin
        frame_vec_t vecs[6];
        frame_vec_t fill[5];
        logic [7:0] fp_bytes[6];
        logic [7:0] cc_bytes[10];
        logic [7:0] got;
        logic [7:0] cur;
        logic [7:0] expv;
        int         next;

        vecs[0] = '{8'h55, 10'b0101010101};
        vecs[1] = '{8'hA3, 10'b0110001011};
        vecs[2] = '{8'hF0, 10'b0000011111};
        vecs[3] = '{8'h00, 10'b0000000001};
        vecs[4] = '{8'hFF, 10'b0111111111};
        vecs[5] = '{8'h81, 10'b0100000011};

        fill[0] = '{8'hA3, 10'b0110001011};
        fill[1] = '{8'h0F, 10'b0111100001};
        fill[2] = '{8'hFF, 10'b0111111111};
        fill[3] = '{8'h00, 10'b0000000001};
        fill[4] = '{8'h81, 10'b0100000011};

        fp_bytes = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'h3C};
        cc_bytes = '{8'hC3, 8'h5A, 8'hE7, 8'h18, 8'h99, 8'h66, 8'h01, 8'hFE, 8'hB4, 8'h2D};

        // Reset held for three cycles.
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_serial", {31'd0, serial_out}, 32'd1);
            check("reset_busy", {31'd0, busy}, 32'd0);
            check("reset_count", {29'd0, fifo_count}, 32'd0);
            check("reset_ready", {31'd0, data_in_ready}, 32'd0);
        end
        rst = 1'b1;
        tick();
        check("ready_after_release", {31'd0, data_in_ready}, 32'd1);
        check("serial_after_release", {31'd0, serial_out}, 32'd1);
        check("busy_after_release", {31'd0, busy}, 32'd0);

        // Single frames from idle, every cycle checked.
        for (int v = 0; v < 6; v++) begin
            send_frame(vecs[v].data, vecs[v].line);
        end

        // Fill to full with five consecutive pushes; frames run back to back.
        data_in = fill[0].data;
        data_in_valid = 1'b1;
        tick();
        data_in = fill[1].data;
        tick();
        for (int c = 0; c < 400; c++) begin
            check($sformatf("fill_f%0d_bit%0d", c / 80, (c % 80) / 8), {31'd0, serial_out},
                  {31'd0, fill[c / 80].line[9 - (c % 80) / 8]});
            if (c == 0) data_in = fill[2].data;
            if (c == 1) data_in = fill[3].data;
            if (c == 2) data_in = fill[4].data;
            if (c == 3) begin
                data_in_valid = 1'b0;
                check("fill_count_full", {29'd0, fifo_count}, 32'd4);
                check("fill_ready_low", {31'd0, data_in_ready}, 32'd0);
            end
            tick();
        end
        check("fill_busy_end", {31'd0, busy}, 32'd0);
        check("fill_line_end", {31'd0, serial_out}, 32'd1);
        check("fill_count_end", {29'd0, fifo_count}, 32'd0);

        // Push held while full, across the cycle of a pop.
        exp_q.delete();
        data_in = fp_bytes[0];
        data_in_valid = 1'b1;
        tick();
        data_in = fp_bytes[1];
        tick();
        cur = 8'h00;
        for (int c = 0; c <= 80; c++) begin
            if (c >= 3 && c < 80) begin
                check("full_count", {29'd0, fifo_count}, 32'd4);
                check("full_ready_low", {31'd0, data_in_ready}, 32'd0);
            end
            if (c % 8 == 4 && c / 8 >= 1 && c / 8 <= 8) cur[c / 8 - 1] = serial_out;
            if (c == 80) begin
                check("full_count_after_pop", {29'd0, fifo_count}, 32'd3);
                check("full_ready_after_pop", {31'd0, data_in_ready}, 32'd1);
            end
            if (c == 0) data_in = fp_bytes[2];
            if (c == 1) data_in = fp_bytes[3];
            if (c == 2) data_in = fp_bytes[4];
            if (c == 3) data_in = fp_bytes[5];
            tick();
        end
        check("full_late_accept_count", {29'd0, fifo_count}, 32'd4);
        check("full_late_accept_ready", {31'd0, data_in_ready}, 32'd0);
        data_in_valid = 1'b0;
        check("full_first_byte", {24'd0, cur}, {24'd0, fp_bytes[0]});
        for (int i = 1; i < 6; i++) exp_q.push_back(fp_bytes[i]);
        while (exp_q.size() > 0) begin
            expv = exp_q.pop_front();
            decode_frame(got);
            check("full_decode", {24'd0, got}, {24'd0, expv});
        end
        check("full_busy_end", {31'd0, busy}, 32'd0);
        check("full_count_end", {29'd0, fifo_count}, 32'd0);

        // Reset in data bit 3 of 0xF0 with two bytes queued.
        data_in = 8'hF0;
        data_in_valid = 1'b1;
        tick();
        data_in = 8'h11;
        tick();
        data_in = 8'h22;
        tick();
        data_in_valid = 1'b0;
        check("midrst_count_before", {29'd0, fifo_count}, 32'd2);
        repeat (34) tick();
        check("midrst_bit3_low", {31'd0, serial_out}, 32'd0);
        rst = 1'b0;
        tick();
        check("midrst_serial", {31'd0, serial_out}, 32'd1);
        check("midrst_count", {29'd0, fifo_count}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_ready", {31'd0, data_in_ready}, 32'd0);
        rst = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            check("midrst_quiet_line", {31'd0, serial_out}, 32'd1);
            check("midrst_quiet_busy", {31'd0, busy}, 32'd0);
        end

        // Concurrent push and pop at every frame boundary, scoreboarded.
        exp_q.delete();
        data_in = cc_bytes[0];
        data_in_valid = 1'b1;
        exp_q.push_back(cc_bytes[0]);
        tick();
        data_in = cc_bytes[1];
        exp_q.push_back(cc_bytes[1]);
        tick();
        data_in_valid = 1'b0;
        next = 2;
        cur = 8'h00;
        for (int c = 0; c < 800; c++) begin
            int o;
            int k;
            o = c % 80;
            k = o / 8;
            if (o == 0) begin
                check($sformatf("cc_count_f%0d", c / 80), {29'd0, fifo_count},
                      (c / 80 <= 8) ? 32'd1 : 32'd0);
            end
            if (o % 8 == 4) begin
                if (k == 0) begin
                    check("cc_start_bit", {31'd0, serial_out}, 32'd0);
                end else if (k <= 8) begin
                    cur[k - 1] = serial_out;
                end else begin
                    check("cc_stop_bit", {31'd0, serial_out}, 32'd1);
                    if (exp_q.size() == 0) begin
                        check("cc_unexpected_frame", {24'd0, cur}, 32'hFFFF_FFFF);
                    end else begin
                        expv = exp_q.pop_front();
                        check("cc_decode", {24'd0, cur}, {24'd0, expv});
                    end
                end
            end
            if (o == 79 && next < 10) begin
                data_in = cc_bytes[next];
                data_in_valid = 1'b1;
                check("cc_ready", {31'd0, data_in_ready}, 32'd1);
                exp_q.push_back(cc_bytes[next]);
                next++;
            end else begin
                data_in_valid = 1'b0;
            end
            tick();
        end
        check("cc_queue_drained", exp_q.size(), 32'd0);
        check("cc_busy_end", {31'd0, busy}, 32'd0);
        check("cc_line_end", {31'd0, serial_out}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
